// File: rtl/demux_stage.sv
// demux_stage: registered 1-to-NUM_OUTPUTS valid/ready demultiplexer with one holding register per lane.
// Latency: 1 cycle from accept to lane valid; o_error pulses the cycle after an out-of-range drop.
// Backpressure: o_ready follows only the selected lane (drain+reload keeps full rate); out-of-range selects are always taken and dropped.
// Optional build macro DEMUX_DROP_CNT_EN adds an 8-bit saturating drop counter on o_drop_count.
module demux_stage #(
  parameter int NUM_OUTPUTS = 4,
  parameter int DATA_WIDTH  = 32,
  localparam int SELECT_BITS = $clog2(NUM_OUTPUTS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic [SELECT_BITS-1:0]            i_select,
  output logic [NUM_OUTPUTS-1:0]            o_valid,
  input  logic [NUM_OUTPUTS-1:0]            i_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] o_data_bus,
  output logic                              o_error
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]                        o_drop_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  localparam logic [SELECT_BITS:0] NUM_LIM = (SELECT_BITS + 1)'(NUM_OUTPUTS);

  lane_state_t           lane_state [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0] lane_data  [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] can_take;
  logic [NUM_OUTPUTS-1:0] load;
  logic                  sel_in_range;
  logic                  drop;

  assign sel_in_range = ({1'b0, i_select} < NUM_LIM);
  assign drop         = i_valid && !sel_in_range;

  // Per-lane space check, selected-lane ready and the one-hot lane load strobe.
  always_comb begin
    can_take = '0;
    load     = '0;
    o_ready  = !sel_in_range;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      can_take[k] = (lane_state[k] == EMPTY) || i_ready[k];
      if (i_select == SELECT_BITS'(k)) begin
        o_ready = can_take[k];
        load[k] = i_valid && can_take[k];
      end
    end
  end

  // Lane holding registers: load on accept (even while draining), empty on drain, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        lane_state[k] <= EMPTY;
        lane_data[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        if (load[k]) begin
          lane_state[k] <= FULL;
          lane_data[k]  <= i_data;
        end else if (i_ready[k]) begin
          lane_state[k] <= EMPTY;
        end
      end
    end
  end

  // One-cycle error pulse following each dropped out-of-range transaction.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_error <= 1'b0;
    else       o_error <= drop;
  end

  for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_lane_out
    assign o_valid[g]                              = (lane_state[g] == FULL);
    assign o_data_bus[g*DATA_WIDTH +: DATA_WIDTH] = lane_data[g];
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;

  // Saturating count of dropped transactions; updates alongside the o_error pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst)                         drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  assign o_drop_count = drop_cnt;
`endif

endmodule

// File: tb/tb_demux_stage.sv
// Bench for demux_stage with NUM_OUTPUTS=6, DATA_WIDTH=8.
// Directed vector table, a stall/drain sequence, then random traffic against a queue-based lane model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled before the next edge.
module tb_demux_stage;

  localparam int N = 6;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           vld_in;
  logic           rdy_out;
  logic [W-1:0]   dat_in;
  logic [2:0]     sel_in;
  logic [N-1:0]   vld_out;
  logic [N-1:0]   rdy_in;
  logic [N*W-1:0] bus_out;
  logic           err_out;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]     drop_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_stage #(.NUM_OUTPUTS(N), .DATA_WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (vld_in),
    .o_ready    (rdy_out),
    .i_data     (dat_in),
    .i_select   (sel_in),
    .o_valid    (vld_out),
    .i_ready    (rdy_in),
    .o_data_bus (bus_out),
    .o_error    (err_out)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .o_drop_count(drop_count)
`endif
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [2:0]   sel;
    logic [7:0]   dat;
    logic [5:0]   rdy;
    logic         c_rdy;   // check o_ready this cycle
    logic         e_rdy;
    logic [5:0]   e_vld;   // after the edge
    logic         e_err;
    int           lane;
    logic [7:0]   e_ldat;
  } vec_t;

  vec_t tbl [25];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lane_dat(input int k);
    return bus_out[k*W +: W];
  endfunction

  task automatic drive(input logic r, input logic v, input logic [2:0] s,
                       input logic [7:0] d, input logic [5:0] rd);
    rst    = r;
    vld_in = v;
    sel_in = s;
    dat_in = d;
    rdy_in = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue-based lane model: each lane is a FIFO of pending items.
  logic [7:0] mq [N][$];
  logic [7:0] mlast [N];
  logic       merr;
  int         mcnt;

  initial begin
    logic       exp_rdy;
    logic       acc;
    logic [5:0] ev;
    logic       r, v;
    logic [2:0] s;
    logic [7:0] d;
    logic [5:0] rd;

    rst = 1'b1; vld_in = 1'b0; sel_in = '0; dat_in = '0; rdy_in = '0;

    //         rst   vld   sel   dat    rdy    c_rdy e_rdy e_vld  err  lane e_ldat
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 5, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 3'd2, 8'hCC, 6'h00, 1'b1, 1'b1, 6'h04, 1'b0, 2, 8'hCC};
    tbl[3]  = '{1'b0, 1'b1, 3'd2, 8'hDD, 6'h00, 1'b1, 1'b0, 6'h04, 1'b0, 2, 8'hCC};
    tbl[4]  = '{1'b0, 1'b1, 3'd2, 8'hDD, 6'h04, 1'b1, 1'b1, 6'h04, 1'b0, 2, 8'hDD};
    tbl[5]  = '{1'b0, 1'b0, 3'd2, 8'h00, 6'h04, 1'b1, 1'b1, 6'h00, 1'b0, 2, 8'hDD};
    tbl[6]  = '{1'b0, 1'b1, 3'd1, 8'h11, 6'h02, 1'b1, 1'b1, 6'h02, 1'b0, 1, 8'h11};
    tbl[7]  = '{1'b0, 1'b1, 3'd1, 8'h22, 6'h02, 1'b1, 1'b1, 6'h02, 1'b0, 1, 8'h22};
    tbl[8]  = '{1'b0, 1'b1, 3'd1, 8'h33, 6'h02, 1'b1, 1'b1, 6'h02, 1'b0, 1, 8'h33};
    tbl[9]  = '{1'b0, 1'b1, 3'd1, 8'h44, 6'h02, 1'b1, 1'b1, 6'h02, 1'b0, 1, 8'h44};
    tbl[10] = '{1'b0, 1'b0, 3'd1, 8'h00, 6'h02, 1'b1, 1'b1, 6'h00, 1'b0, 1, 8'h44};
    tbl[11] = '{1'b0, 1'b1, 3'd0, 8'hAA, 6'h00, 1'b1, 1'b1, 6'h01, 1'b0, 0, 8'hAA};
    tbl[12] = '{1'b0, 1'b1, 3'd5, 8'hBB, 6'h00, 1'b1, 1'b1, 6'h21, 1'b0, 5, 8'hBB};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 6'h00, 1'b1, 1'b0, 6'h21, 1'b0, 0, 8'hAA};
    tbl[14] = '{1'b0, 1'b1, 3'd7, 8'hEE, 6'h00, 1'b1, 1'b1, 6'h21, 1'b1, 0, 8'hAA};
    tbl[15] = '{1'b0, 1'b0, 3'd7, 8'h00, 6'h00, 1'b1, 1'b1, 6'h21, 1'b0, 5, 8'hBB};
    tbl[16] = '{1'b0, 1'b1, 3'd6, 8'hEE, 6'h00, 1'b1, 1'b1, 6'h21, 1'b1, 5, 8'hBB};
    tbl[17] = '{1'b0, 1'b1, 3'd6, 8'hEF, 6'h00, 1'b1, 1'b1, 6'h21, 1'b1, 0, 8'hAA};
    tbl[18] = '{1'b0, 1'b0, 3'd0, 8'h00, 6'h00, 1'b1, 1'b0, 6'h21, 1'b0, 0, 8'hAA};
    tbl[19] = '{1'b0, 1'b1, 3'd3, 8'h33, 6'h00, 1'b1, 1'b1, 6'h29, 1'b0, 3, 8'h33};
    tbl[20] = '{1'b0, 1'b1, 3'd4, 8'h44, 6'h00, 1'b1, 1'b1, 6'h39, 1'b0, 4, 8'h44};
    tbl[21] = '{1'b1, 1'b1, 3'd3, 8'h99, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 3, 8'h00};
    tbl[22] = '{1'b0, 1'b0, 3'd0, 8'h00, 6'h00, 1'b1, 1'b1, 6'h00, 1'b0, 4, 8'h00};
    tbl[23] = '{1'b0, 1'b1, 3'd7, 8'hEE, 6'h00, 1'b1, 1'b1, 6'h00, 1'b1, 0, 8'h00};
    tbl[24] = '{1'b1, 1'b0, 3'd0, 8'h00, 6'h00, 1'b0, 1'b0, 6'h00, 1'b0, 0, 8'h00};

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].dat, tbl[i].rdy);
      if (tbl[i].c_rdy) check($sformatf("vec%0d o_ready", i), 64'(rdy_out), 64'(tbl[i].e_rdy));
      tick();
      check($sformatf("vec%0d o_valid", i), 64'(vld_out), 64'(tbl[i].e_vld));
      check($sformatf("vec%0d o_error", i), 64'(err_out), 64'(tbl[i].e_err));
      check($sformatf("vec%0d lane%0d data", i, tbl[i].lane), 64'(lane_dat(tbl[i].lane)),
            64'(tbl[i].e_ldat));
    end

    // Stalled lane holds valid and data over several cycles, then drains once.
    drive(1'b0, 1'b1, 3'd3, 8'h5A, 6'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 6'h37);  // every lane ready except lane 3
      tick();
      check("stall valid", 64'(vld_out), 64'h08);
      check("stall data", 64'(lane_dat(3)), 64'h5A);
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 6'h08);
    tick();
    check("drain valid", 64'(vld_out), 64'h00);
    check("drain hold data", 64'(lane_dat(3)), 64'h5A);

`ifdef DEMUX_DROP_CNT_EN
    drive(1'b1, 1'b0, 3'd0, 8'h00, 6'h00);
    tick();
    check("cnt reset", 64'(drop_count), 64'd0);
    drive(1'b0, 1'b1, 3'd7, 8'hEE, 6'h00);
    tick();
    check("cnt first drop", 64'(drop_count), 64'd1);
    check("cnt first err", 64'(err_out), 64'd1);
    for (int i = 0; i < 300; i++) tick();
    check("cnt saturate", 64'(drop_count), 64'd255);
`endif

    // Random traffic against the queue model, starting from reset.
    drive(1'b1, 1'b0, 3'd0, 8'h00, 6'h00);
    tick();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      mlast[k] = 8'h00;
    end
    merr = 1'b0;
    mcnt = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = 1'($urandom_range(0, 1));
      s  = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      rd = 6'($urandom);
      drive(r, v, s, d, rd);

      if (s < 3'(N)) exp_rdy = (mq[s].size() == 0) || rd[s];
      else           exp_rdy = 1'b1;
      if (!r) check("rand o_ready", 64'(rdy_out), 64'(exp_rdy));
      tick();

      if (r) begin
        for (int k = 0; k < N; k++) begin
          mq[k].delete();
          mlast[k] = 8'h00;
        end
        merr = 1'b0;
        mcnt = 0;
      end else begin
        for (int k = 0; k < N; k++)
          if (mq[k].size() > 0 && rd[k]) void'(mq[k].pop_front());
        acc  = v && exp_rdy;
        merr = acc && (s >= 3'(N));
        if (acc && s < 3'(N)) begin
          mq[s].push_back(d);
          mlast[s] = d;
        end
        if (merr && mcnt < 255) mcnt++;
      end

      for (int k = 0; k < N; k++) ev[k] = (mq[k].size() > 0);
      check("rand o_valid", 64'(vld_out), 64'(ev));
      check("rand o_error", 64'(err_out), 64'(merr));
      for (int k = 0; k < N; k++) begin
        if (mq[k].size() > 0) check($sformatf("rand lane%0d data", k), 64'(lane_dat(k)), 64'(mq[k][0]));
        else                  check($sformatf("rand lane%0d hold", k), 64'(lane_dat(k)), 64'(mlast[k]));
      end
`ifdef DEMUX_DROP_CNT_EN
      check("rand drop_count", 64'(drop_count), 64'(mcnt));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stage.md
Name: demux_stage

Overview:
- Registered 1-to-N stream demultiplexer: one valid/ready input stream plus a destination select, routed to one of NUM_OUTPUTS valid/ready output lanes.
- Each lane has a one-entry holding register, so stalls on one lane do not stall transfers to other lanes.
- Serves as the dispatch-side counterpart of the operand/result muxes, e.g. issuing decoded ops to functional units.

Parameters:
- NUM_OUTPUTS, 4, number of output lanes (>= 2)
- DATA_WIDTH, 32, payload width in bits
- SELECT_BITS, $clog2(NUM_OUTPUTS), derived localparam; not overridable

Ports:
- i_clk  input  1  clock; all state updates on the rising edge
- i_rst  input  1  synchronous, active-high reset
- i_valid  input  1  input transaction present
- o_ready  output  1  input transaction accepted this cycle when i_valid is also high
- i_data  input  DATA_WIDTH  input payload
- i_select  input  SELECT_BITS  destination lane index
- o_valid  output  NUM_OUTPUTS  per-lane valid; bit k belongs to lane k
- i_ready  input  NUM_OUTPUTS  per-lane downstream ready
- o_data_bus  output  NUM_OUTPUTS*DATA_WIDTH  lane k payload is bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_error  output  1  one-cycle pulse when an out-of-range select is dropped

Behaviour:
- Reset (i_rst high at a clock edge):
  - all o_valid bits go to 0, all lane data goes to 0, o_error goes to 0.
  - Any occupied lane is discarded.
  - Reset has priority over every other event in the same cycle.
- Lane state is exactly 2 states, EMPTY (valid=0) and FULL (valid=1):
  - EMPTY -> FULL on accept to this lane.
  - FULL -> EMPTY on drain (i_ready[k] high) with no accept to this lane.
  - FULL -> FULL on drain plus accept in the same cycle: new data loads and valid stays 1, giving full throughput.
  - FULL with no drain: holds both data and valid (stall).
- Lane k can take data when o_valid[k]==0 or i_ready[k]==1.
- o_ready (combinational):
  - If i_select < NUM_OUTPUTS: o_ready equals "lane i_select can take data".
  - If i_select >= NUM_OUTPUTS: o_ready = 1, and the transaction is consumed and dropped.
  - o_ready does not depend on i_valid.
- Accept occurs when i_valid && o_ready. On accept with an in-range select:
  - the lane's data register loads i_data at the edge;
  - o_valid[sel] becomes 1 in the next cycle. Latency is 1 cycle from accept to visibility.
- Drop: an accept with an out-of-range select sets o_error=1 for exactly the following cycle. No lane changes.
- Ordering and routing:
  - Per-lane order is preserved; there is no reordering.
  - Other lanes are untouched by an accept to lane k.
  - Only one lane can be loaded per cycle; any number of lanes can drain in the same cycle.
- Lane data holds its value while EMPTY. It updates only on accept or reset.
- i_data and i_select are sampled only on accept; their values when i_valid==0 are ignored.
- Drain handshake: lane k transfers when o_valid[k] && i_ready[k]. o_valid[k] and lane data stay stable until that transfer.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port o_drop_count, 8 bits.
  - Increments on every dropped (out-of-range) accept; the new value is visible in the same cycle as the o_error pulse.
  - Saturates at 255 with no wrap.
  - Cleared to 0 by i_rst.
- Not defined: the port and counter are absent. o_error behaviour is identical in both builds.

Test Plan (NUM_OUTPUTS=6, DATA_WIDTH=8):
- Basic routing:
  - Stimulus: reset 2 cycles, then i_valid=1, i_select=2, i_data=0xCC, all i_ready=0.
  - Response: o_ready=1; next cycle o_valid=6'b000100 and lane2 data=0xCC. Subsequent sends to lane 2 see o_ready=0 until i_ready[2]=1.
- Full throughput:
  - Stimulus: i_ready[1]=1 held, 4 back-to-back accepts to select=1 with data 0x11,0x22,0x33,0x44.
  - Response: o_ready=1 every cycle; lane1 shows 0x11..0x44 on consecutive cycles; o_valid[1] drops the cycle after the last drain.
- Independent lanes:
  - Stimulus: lane0 FULL with 0xAA and i_ready[0]=0, then send 0xBB to select=5.
  - Response: accepted; o_valid=6'b100001; lane0 holds 0xAA unchanged.
- Out-of-range select:
  - Stimulus: i_select=7, i_data=0xEE, i_valid=1.
  - Response: o_ready=1, o_error=1 for exactly one cycle, o_valid unchanged.
  - With DEMUX_DROP_CNT_EN: o_drop_count 0->1; after 300 drops it reads 255.
- Reset mid-operation:
  - Stimulus: lanes 0, 3 and 4 FULL, assert i_rst for one cycle while i_valid=1, i_select=3.
  - Response: next cycle o_valid=0, all lane data=0x00, o_error=0; the concurrent input is not captured.
